// File: rtl/button_debouncer.sv
// Push-button conditioner: per-channel 2-flop synchroniser, stability-counter debounce,
// and optional registered press pulse (enabled by defining BUTTON_DEBOUNCER_PULSE_EN).
module button_debouncer #(
    parameter int NUM_BTNS        = 3,
    parameter int DEBOUNCE_CYCLES = 120000
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [NUM_BTNS-1:0] btn_n,
    output logic [NUM_BTNS-1:0] btn_level,
    output logic [NUM_BTNS-1:0] btn_press
);

    localparam int               CNT_W    = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    // Count never runs past the acceptance point, even if the compare is bypassed.
    function automatic logic [CNT_W-1:0] cnt_inc(input logic [CNT_W-1:0] c);
        return (c >= CNT_LAST) ? CNT_LAST : c + CNT_W'(1);
    endfunction

    logic [NUM_BTNS-1:0] sync1_p0;
    logic [NUM_BTNS-1:0] sync2_p1;
    logic [NUM_BTNS-1:0] s_p1;
    logic [NUM_BTNS-1:0] accept_p1;

    // Stage 0/1: synchroniser, reset to the released (high) pin level
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_p0 <= '1;
            sync2_p1 <= '1;
        end else begin
            sync1_p0 <= btn_n;
            sync2_p1 <= sync1_p0;
        end
    end

    assign s_p1 = ~sync2_p1;

    // Stage 2: per-channel stability counter and accepted level
    for (genvar i = 0; i < NUM_BTNS; i++) begin : g_chan
        logic             stable_p2;
        logic [CNT_W-1:0] cnt_p2;

        assign accept_p1[i] = (s_p1[i] != stable_p2) && (cnt_p2 == CNT_LAST);
        assign btn_level[i] = stable_p2;

        always_ff @(posedge clk) begin
            if (rst) begin
                stable_p2 <= 1'b0;
                cnt_p2    <= '0;
            end else if (s_p1[i] == stable_p2) begin
                cnt_p2 <= '0;
            end else if (accept_p1[i]) begin
                stable_p2 <= s_p1[i];
                cnt_p2    <= '0;
            end else begin
                cnt_p2 <= cnt_inc(cnt_p2);
            end
        end
    end

`ifdef BUTTON_DEBOUNCER_PULSE_EN
    logic [NUM_BTNS-1:0] press_p2;

    // Pulse is registered on the same edge that raises the level, so both appear together.
    always_ff @(posedge clk) begin
        if (rst) begin
            press_p2 <= '0;
        end else begin
            press_p2 <= accept_p1 & s_p1;
        end
    end

    assign btn_press = press_p2;
`else
    assign btn_press = '0;
`endif

endmodule

// File: tb/tb_button_debouncer.sv
// Scoreboard bench for button_debouncer (NUM_BTNS=3, DEBOUNCE_CYCLES=4): stimulus queues
// expected output events, a monitor pops and checks them whenever the outputs change.
module tb_button_debouncer;

    localparam int LAT = 6;  // drive after edge n -> new level after edge n+6
`ifdef BUTTON_DEBOUNCER_PULSE_EN
    localparam logic [2:0] PMASK = 3'b111;
`else
    localparam logic [2:0] PMASK = 3'b000;
`endif

    typedef struct {
        int       cyc;
        logic [2:0] lvl;
        logic [2:0] prs;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [2:0] btn_n = 3'b000;
    logic [2:0] btn_level;
    logic [2:0] btn_press;

    int   cyc = 0;
    logic rst_seen = 1'b0;
    logic done = 1'b0;
    int   tests = 0;
    int   fails = 0;
    exp_t q[$];

    button_debouncer #(
        .NUM_BTNS       (3),
        .DEBOUNCE_CYCLES(4)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .btn_n    (btn_n),
        .btn_level(btn_level),
        .btn_press(btn_press)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        cyc      <= cyc + 1;
        rst_seen <= rst;
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic expect_ev(input int c, input logic [2:0] l, input logic [2:0] p);
        exp_t e;
        e.cyc = c;
        e.lvl = l;
        e.prs = p & PMASK;
        q.push_back(e);
    endtask

    // Stimulus
    initial begin
        logic [8:0] seq;
        seq = 9'b000001000;

        // reset held 3 cycles with all buttons pressed
        tick(3);
        rst = 1'b0;
        expect_ev(cyc + LAT, 3'b111, 3'b111);
        tick(10);

        // release all
        btn_n = 3'b111;
        expect_ev(cyc + LAT, 3'b000, 3'b000);
        tick(10);

        // clean press and release on channel 0
        btn_n = 3'b110;
        expect_ev(cyc + LAT, 3'b001, 3'b001);
        tick(10);
        btn_n = 3'b111;
        expect_ev(cyc + LAT, 3'b000, 3'b000);
        tick(10);

        // bounce on channel 1: 0,0,0,1,0,0,0,0,0
        for (int j = 0; j < 9; j++) begin
            btn_n = {1'b1, seq[j], 1'b1};
            if (j == 4) expect_ev(cyc + LAT, 3'b010, 3'b010);
            tick(1);
        end
        tick(5);
        btn_n = 3'b111;
        expect_ev(cyc + LAT, 3'b000, 3'b000);
        tick(10);

        // 3-cycle glitch on channel 2: no event expected
        btn_n = 3'b011;
        tick(3);
        btn_n = 3'b111;
        tick(10);

        // channel 2 pressed, then reset while channel 0 is mid-count
        btn_n = 3'b011;
        expect_ev(cyc + LAT, 3'b100, 3'b100);
        tick(10);
        btn_n = 3'b010;
        tick(4);
        rst = 1'b1;
        expect_ev(cyc + 1, 3'b000, 3'b000);
        tick(1);
        rst = 1'b0;
        expect_ev(cyc + LAT, 3'b101, 3'b101);
        tick(12);
        btn_n = 3'b111;
        expect_ev(cyc + LAT, 3'b000, 3'b000);
        tick(10);
        done = 1'b1;
    end

    // Monitor / scoreboard
    initial begin
        logic [2:0] prev_level;
        exp_t       e;
        prev_level = 3'b000;
        forever begin
            @(negedge clk);
            if (cyc >= 1) begin
                if (rst_seen) begin
                    tests += 2;
                    if (btn_level !== 3'b000) begin
                        fails++;
                        $display("FAIL reset_level cyc=%0d got=%b want=000", cyc, btn_level);
                    end
                    if (btn_press !== 3'b000) begin
                        fails++;
                        $display("FAIL reset_press cyc=%0d got=%b want=000", cyc, btn_press);
                    end
                end
                if (btn_level !== prev_level || btn_press !== 3'b000) begin
                    if (q.size() == 0) begin
                        tests++;
                        fails++;
                        $display("FAIL unexpected_event cyc=%0d level=%b press=%b want=no change",
                                 cyc, btn_level, btn_press);
                    end else begin
                        e = q.pop_front();
                        tests += 3;
                        if (cyc != e.cyc) begin
                            fails++;
                            $display("FAIL event_cycle got=%0d want=%0d", cyc, e.cyc);
                        end
                        if (btn_level !== e.lvl) begin
                            fails++;
                            $display("FAIL event_level cyc=%0d got=%b want=%b", cyc, btn_level, e.lvl);
                        end
                        if (btn_press !== e.prs) begin
                            fails++;
                            $display("FAIL event_press cyc=%0d got=%b want=%b", cyc, btn_press, e.prs);
                        end
                    end
                end
                prev_level = btn_level;
            end
            if (done || cyc > 1000) begin
                tests++;
                if (!done) begin
                    fails++;
                    $display("FAIL timeout cyc=%0d got=not done want=done", cyc);
                end else if (q.size() != 0) begin
                    fails++;
                    $display("FAIL missing_events got=%0d pending want=0", q.size());
                end
                $display("[TB] %0d tests run, %0d failed", tests, fails);
                $finish;
            end
        end
    end

endmodule

// File: doc/button_debouncer.md
# button_debouncer

Conditions the three active-low push-button inputs that feed the full adder's A, B and C_IN operands. Each channel is synchronised to `clk`, debounced by a per-channel stability counter, and presented as a clean active-high level. An optional one-cycle press pulse per channel is also produced. The adder consumes `btn_level` directly, so it no longer inverts raw pmod pins.

## Interface
Parameters:
- `NUM_BTNS`, 3: number of independent button channels.
- `DEBOUNCE_CYCLES`, 120000: consecutive stable cycles required to accept a new level. This is 10 ms at 12 MHz. Legal range is ≥ 1.

Ports:
- `clk`  in  1  system clock; all logic is on its rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `btn_n`  in  NUM_BTNS  raw button pins; active-low, asynchronous, bouncy.
- `btn_level`  out  NUM_BTNS  debounced level; 1 = pressed.
- `btn_press`  out  NUM_BTNS  one-cycle pulse on each accepted press.

## Operation
Each channel `i` is fully independent. There is no shared state between channels.

- **Synchroniser:** a two-flop chain (`sync1`, `sync2`) samples `btn_n[i]`. Both flops reset to 1, which is the released state. `s = ~sync2` is the active-high synchronised sample.
- **Debounce state:** `stable` register (drives `btn_level[i]`) and counter `cnt`.
  - `cnt` width is `$clog2(DEBOUNCE_CYCLES+1)`.
  - `cnt` never exceeds `DEBOUNCE_CYCLES-1`.
- **Per-cycle update, in priority order:**
  - `rst`: `sync1 = sync2 = 1`, `stable = 0`, `cnt = 0`, `btn_press[i] = 0`.
  - `s == stable`: `cnt <= 0`. Any bounce back to the old level therefore restarts the count.
  - `s != stable` and `cnt == DEBOUNCE_CYCLES-1`: `stable <= s`, `cnt <= 0`.
  - `s != stable` otherwise: `cnt <= cnt + 1`.
- **Press pulse:** `btn_press[i]` is registered. It is 1 for exactly the cycle after the edge where `stable` goes 0→1, and 0 otherwise. Releases (1→0) produce no pulse.
- **Reset mid-count:** the partial count is discarded. A button held through reset is re-detected as a press afterwards, with full latency and a press pulse.
- **Simultaneous channels:** presses on several channels in the same cycle each produce their own pulse in the same cycle.

## Timing
- **Output reset values:** `btn_level` = 0 and `btn_press` = 0 in the cycle after any `rst` edge.
- **Latency:** suppose `btn_n[i]` settles to a new value before rising edge k, and holds through edge k+1+DEBOUNCE_CYCLES.
  - `sync1` captures it at edge k.
  - `stable` (and therefore `btn_level[i]`) updates at edge k+1+DEBOUNCE_CYCLES.
  - `btn_press[i]` is high in the same cycle that `btn_level[i]` first reads 1.
- **Glitch rejection:** an input pulse shorter than DEBOUNCE_CYCLES cycles (measured at `sync2`) never changes `btn_level`.
- **Bounce handling:** a bounce restarts latency from the first sample of the final settled level.
- **Combinational paths:** there is no path from `btn_n` to any output. All outputs come directly from flops.

## Configuration
- **`BUTTON_DEBOUNCER_PULSE_EN`**
  - Defined: `btn_press` logic is built as described above.
  - Undefined: the `btn_press` flops are not instantiated and `btn_press` is tied to all zeros.
  - In both cases `btn_level` behaviour is unchanged and the port list is identical.

## Test plan
All scenarios use `NUM_BTNS=3` and `DEBOUNCE_CYCLES=4`, with `BUTTON_DEBOUNCER_PULSE_EN` defined unless stated.

- **Reset:** hold `btn_n=3'b000` with `rst=1` for 3 cycles. → `btn_level=0` and `btn_press=0` during reset. After `rst` falls, `btn_level` becomes 3'b111 at edge 1+4 relative to the first post-reset sample. `btn_press=3'b111` for exactly one cycle.
- **Clean press and release:** drop `btn_n[0]` 1→0 before edge k and hold.
  - → `btn_level[0]` rises at edge k+5, with a one-cycle `btn_press[0]`.
  - Release later: `btn_level[0]` falls 5 edges after the sample edge, and no pulse is produced.
- **Bounce:** `btn_n[1]` sequence 0,0,0,1,0,0,0,0,0 (one value per cycle). → No change until the final 0-run. `btn_level[1]` rises at edge 5 counted from the sample edge of the last 1→0 transition.
- **Glitch:** `btn_n[2]` low for 3 cycles, then high. → `btn_level[2]` stays 0 and `btn_press[2]` never asserts.
- **Reset mid-count:** start a press on channel 0, then assert `rst` for 1 cycle when `cnt=2`, holding the button low. → Outputs clear. The press is re-accepted with full 2+4-cycle latency after reset and pulses once.
- **Macro off:** build without `BUTTON_DEBOUNCER_PULSE_EN` and repeat the clean-press scenario. → `btn_level` timing is identical and `btn_press` stays 3'b000 throughout.
